fir_mul_pipe: RTL and testbench

//  Parametrised pipelined signed multiplier for the FIR datapath: coeff x sample.

---
 rtl/fir_mul_pkg.sv | 45 ++++
 rtl/fir_mul_round_sat.sv | 44 ++++
 rtl/fir_mul_pipe.sv | 115 +++++++++++
 tb/tb_fir_mul_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mul_pkg.sv
// Shared constants, parameter range checks and the saturating narrow helper
// for the FIR coefficient x sample multiplier.
package fir_mul_pkg;

  localparam int DEF_A_W    = 6;
  localparam int DEF_B_W    = 32;
  localparam int DEF_PROD_W = DEF_A_W + DEF_B_W;

  // Widest intermediate the narrowing helper works on; products must stay below it.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic signed [MAX_W-1:0] value;
    logic                    sat;
  } narrow_t;

  function automatic bit stage_ok(input int num_stage);
    return (num_stage >= 1) && (num_stage <= 4);
  endfunction

  function automatic bit shift_ok(input int shift, input int prod_w);
    return (shift >= 0) && (shift < prod_w) && (prod_w < MAX_W);
  endfunction

  // Clamp value to the signed range of 'width' bits and report whether it clipped.
  function automatic narrow_t sat_narrow(input logic signed [MAX_W-1:0] value,
                                         input int                      width);
    narrow_t                 res;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (MAX_W'(1) <<< (width - 1)) - MAX_W'(1);
    lo = ~hi;
    res.value = value;
    res.sat   = 1'b0;
    if (value > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (value < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mul_round_sat.sv
// Combinational round-half-up arithmetic shift and narrowing of the full product.
// FIR_MUL_SAT_EN selects clamping to the output range; otherwise the result wraps.
module fir_mul_round_sat
  import fir_mul_pkg::*;
#(
  parameter int IN_W  = DEF_PROD_W,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  prod,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // One guard bit so adding the rounding half can never overflow.
  logic signed [IN_W:0]    rounded;
  logic signed [MAX_W-1:0] wide;

  if (SHIFT > 0) begin : g_round
    localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    logic signed [IN_W:0] sum;
    assign sum     = {prod[IN_W-1], prod} + HALF;
    assign rounded = sum >>> SHIFT;
  end else begin : g_pass
    assign rounded = {prod[IN_W-1], prod};
  end

  assign wide = {{(MAX_W-IN_W-1){rounded[IN_W]}}, rounded};

`ifdef FIR_MUL_SAT_EN
  narrow_t narrowed;
  logic    unused_hi;
  assign narrowed  = sat_narrow(wide, OUT_W);
  assign dout      = narrowed.value[OUT_W-1:0];
  assign sat       = narrowed.sat;
  assign unused_hi = ^narrowed.value[MAX_W-1:OUT_W];
`else
  logic unused_hi;
  assign dout      = wide[OUT_W-1:0];
  assign sat       = 1'b0;
  assign unused_hi = ^wide[MAX_W-1:OUT_W];
`endif

endmodule

// File: rtl/fir_mul_pipe.sv
// Pipelined signed coeff x sample multiplier with valid/ready flow control.
// Optional macro FIR_MUL_SAT_EN: clamp out-of-range results and raise sat_flag.
module fir_mul_pipe
  import fir_mul_pkg::*;
#(
  parameter int A_W       = DEF_A_W,
  parameter int B_W       = DEF_B_W,
  parameter int OUT_W     = 32,
  parameter int NUM_STAGE = 2,
  parameter int SHIFT     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat_flag
);

  localparam int PROD_W = A_W + B_W;

  if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
    $error("fir_mul_pipe: NUM_STAGE must be in 1..4");
  end
  if (!shift_ok(SHIFT, PROD_W)) begin : g_bad_shift
    $error("fir_mul_pipe: SHIFT must be in 0..A_W+B_W-1");
  end

  // Handshake: a word moves into the pipe when in_valid & in_ready, and out of it
  // when out_valid & out_ready & ce. Every stage shifts on the single adv enable,
  // so the output holds steady whenever it is valid and not taken.
  logic adv;
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_STAGE - 1; k++) begin : g_op
    logic                  v_d;
    logic signed [A_W-1:0] a_d;
    logic signed [B_W-1:0] b_d;
    logic                  v_q;
    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;

    if (k == 0) begin : g_head
      assign v_d = in_valid;
      assign a_d = din0;
      assign b_d = din1;
    end else begin : g_link
      assign v_d = g_op[k-1].v_q;
      assign a_d = g_op[k-1].a_q;
      assign b_d = g_op[k-1].b_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  logic                  last_v;
  logic signed [A_W-1:0] last_a;
  logic signed [B_W-1:0] last_b;

  if (NUM_STAGE == 1) begin : g_direct
    assign last_v = in_valid;
    assign last_a = din0;
    assign last_b = din1;
  end else begin : g_tail
    assign last_v = g_op[NUM_STAGE-2].v_q;
    assign last_a = g_op[NUM_STAGE-2].a_q;
    assign last_b = g_op[NUM_STAGE-2].b_q;
  end

  // Full-width product is exact even for most-negative x most-negative.
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  res;
  logic                     res_sat;

  assign prod = PROD_W'(last_a) * PROD_W'(last_b);

  fir_mul_round_sat #(
    .IN_W  (PROD_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .prod (prod),
    .dout (res),
    .sat  (res_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat_flag  <= 1'b0;
    end else if (adv) begin
      out_valid <= last_v;
      dout      <= res;
      sat_flag  <= res_sat & last_v;
    end
  end

endmodule

// File: tb/tb_fir_mul_pipe.sv
// Directed bench for fir_mul_pipe: default instance plus a SHIFT=4 instance.
module tb_fir_mul_pipe;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] b;
    logic [31:0] d;
    logic        s;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  din0 = '0;
  logic [31:0] din1 = '0;
  logic        s_valid = 1'b0;
  logic [5:0]  s_din0 = '0;
  logic [31:0] s_din1 = '0;

  logic        in_ready, out_valid, sat_flag;
  logic [31:0] dout;
  logic        s_in_ready, s_out_valid, s_sat_flag;
  logic [31:0] s_dout;

  int checks = 0;
  int passed = 0;
  logic [32:0] exp_q[$];
  logic [32:0] s_exp_q[$];

  vec_t vt[12];
  vec_t vs[6];
  vec_t z;

  fir_mul_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .sat_flag(sat_flag)
  );

  fir_mul_pipe #(.SHIFT(4)) dut_s4 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(s_valid), .in_ready(s_in_ready),
    .din0(s_din0), .din1(s_din1), .out_valid(s_out_valid), .out_ready(out_ready),
    .dout(s_dout), .sat_flag(s_sat_flag)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] a, input logic [31:0] b,
                              input logic [31:0] d, input logic s);
    vec_t v;
    v.a = a; v.b = b; v.d = d; v.s = s;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, required %b", name, act, req);
  endtask

  task automatic note_extra(input string name);
    checks++;
    $display("FAIL %s: got an output, required none pending", name);
  endtask

  // One clock: drive on the falling edge, then score what the next rising edge will move.
  task automatic cycle(input logic v, input vec_t x, input logic sv, input vec_t sx,
                       input logic ordy, input logic ce_i);
    logic [32:0] e;
    @(negedge clk);
    in_valid = v;  din0 = x.a;    din1 = x.b;
    s_valid = sv;  s_din0 = sx.a; s_din1 = sx.b;
    out_ready = ordy;
    ce = ce_i;
    #1;
    if (in_valid && in_ready) exp_q.push_back({x.s, x.d});
    if (s_valid && s_in_ready) s_exp_q.push_back({sx.s, sx.d});
    if (out_valid && out_ready && ce) begin
      if (exp_q.size() == 0) note_extra("out_extra");
      else begin
        e = exp_q.pop_front();
        check32("dout", dout, e[31:0]);
        check1("sat_flag", sat_flag, e[32]);
      end
    end
    if (s_out_valid && out_ready && ce) begin
      if (s_exp_q.size() == 0) note_extra("s4_out_extra");
      else begin
        e = s_exp_q.pop_front();
        check32("s4_dout", s_dout, e[31:0]);
        check1("s4_sat_flag", s_sat_flag, e[32]);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || s_exp_q.size() != 0) && n < 20) begin
      cycle(1'b0, z, 1'b0, z, 1'b1, 1'b1);
      n++;
    end
    check32("drain_left", exp_q.size() + s_exp_q.size(), 32'd0);
  endtask

  initial begin
    int idx;
    logic hold;
    z = mk(6'h00, 32'h0, 32'h0, 1'b0);

    vt[0]  = mk(6'h3D, 32'd100,        32'hFFFFFED4, 1'b0);  // -3 * 100
    vt[4]  = mk(6'h00, 32'd12345,      32'h00000000, 1'b0);
    vt[5]  = mk(6'h01, 32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0);  // 1 * -1
    vt[6]  = mk(6'h05, 32'd1000,       32'h00001388, 1'b0);
    vt[8]  = mk(6'h3F, 32'h7FFFFFFF,   32'h80000001, 1'b0);  // -1 * max
    vt[9]  = mk(6'h02, 32'h3FFFFFFF,   32'h7FFFFFFE, 1'b0);
    vt[10] = mk(6'h1F, 32'd1,          32'h0000001F, 1'b0);
    vt[11] = mk(6'h20, 32'hFFFFFFFF,   32'h00000020, 1'b0);  // -32 * -1
`ifdef FIR_MUL_SAT_EN
    vt[1]  = mk(6'h20, 32'h7FFFFFFF,   32'h80000000, 1'b1);
    vt[2]  = mk(6'h20, 32'h80000000,   32'h7FFFFFFF, 1'b1);
    vt[3]  = mk(6'h1F, 32'h7FFFFFFF,   32'h7FFFFFFF, 1'b1);
    vt[7]  = mk(6'h3F, 32'h80000000,   32'h7FFFFFFF, 1'b1);
`else
    vt[1]  = mk(6'h20, 32'h7FFFFFFF,   32'h00000020, 1'b0);
    vt[2]  = mk(6'h20, 32'h80000000,   32'h00000000, 1'b0);
    vt[3]  = mk(6'h1F, 32'h7FFFFFFF,   32'h7FFFFFE1, 1'b0);
    vt[7]  = mk(6'h3F, 32'h80000000,   32'h80000000, 1'b0);
`endif

    vs[0] = mk(6'h07, 32'd9,        32'h00000004, 1'b0);  // 63 -> 4
    vs[1] = mk(6'h39, 32'd9,        32'hFFFFFFFC, 1'b0);  // -63 -> -4
    vs[2] = mk(6'h01, 32'd8,        32'h00000001, 1'b0);  // 8 -> 1, half rounds up
    vs[3] = mk(6'h01, 32'd7,        32'h00000000, 1'b0);  // 7 -> 0
    vs[4] = mk(6'h3F, 32'd8,        32'h00000000, 1'b0);  // -8 -> 0
    vs[5] = mk(6'h3F, 32'd24,       32'hFFFFFFFF, 1'b0);  // -24 -> -1

    // Reset state
    ce = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_dout", dout, 32'h0);
    check1("rst_sat_flag", sat_flag, 1'b0);
    check1("rst_s4_out_valid", s_out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Latency: accepted input shows up exactly two cycles later
    cycle(1'b1, vt[0], 1'b0, z, 1'b1, 1'b1);
    cycle(1'b0, z, 1'b0, z, 1'b1, 1'b1);
    check1("lat_valid_early", out_valid, 1'b0);
    cycle(1'b0, z, 1'b0, z, 1'b1, 1'b1);
    check1("lat_valid", out_valid, 1'b1);
    drain();

    // Back-to-back table sweep at full throughput
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vt[i], 1'b0, z, 1'b1, 1'b1);
      check1("tab_in_ready", in_ready, 1'b1);
    end
    drain();

    // Rounding right shift on the SHIFT=4 instance
    for (int i = 0; i < 6; i++) cycle(1'b0, z, 1'b1, vs[i], 1'b1, 1'b1);
    drain();

    // Downstream stall of five cycles once the first result is valid
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      hold = (cyc >= 2 && cyc < 7);
      cycle(1'b1, vt[idx], 1'b0, z, !hold, 1'b1);
      if (hold) begin
        check1("stall_in_ready", in_ready, 1'b0);
        check1("stall_out_valid", out_valid, 1'b1);
        check32("stall_dout", dout, vt[0].d);
      end
      if (in_valid && in_ready) idx++;
    end
    check32("stall_fed", idx, 32'd6);
    drain();

    // Clock enable low for three cycles mid-stream
    idx = 6;
    for (int cyc = 0; cyc < 40 && idx < 12; cyc++) begin
      hold = (cyc >= 3 && cyc < 6);
      cycle(1'b1, vt[idx], 1'b0, z, 1'b1, !hold);
      if (hold) begin
        check1("ce_in_ready", in_ready, 1'b0);
        check1("ce_out_valid", out_valid, 1'b1);
        check32("ce_dout", dout, exp_q[0][31:0]);
      end
      if (in_valid && in_ready) idx++;
    end
    check32("ce_fed", idx, 32'd12);
    drain();

    // Asynchronous reset while a result is valid
    cycle(1'b1, vt[1], 1'b0, z, 1'b1, 1'b1);
    cycle(1'b1, vt[6], 1'b0, z, 1'b1, 1'b1);
    cycle(1'b0, z, 1'b0, z, 1'b1, 1'b1);
    check1("pre_rst_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check32("mid_rst_dout", dout, 32'h0);
    check1("mid_rst_sat_flag", sat_flag, 1'b0);
    exp_q.delete();
    s_exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, vt[9], 1'b0, z, 1'b1, 1'b1);
    cycle(1'b0, z, 1'b0, z, 1'b1, 1'b1);
    check1("post_rst_valid_early", out_valid, 1'b0);
    cycle(1'b0, z, 1'b0, z, 1'b1, 1'b1);
    check1("post_rst_valid", out_valid, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
